// File: rtl/led_chase_monitor.sv
// Receive-side checker for a rotating one-hot LED chaser: decodes the lit position,
// locks onto the rotation direction, counts laps and flags illegal patterns or jumps.
module led_chase_monitor #(
  parameter int WIDTH      = 8,
  parameter int LAP_W      = 8,
  parameter int LOCK_STEPS = 2
) (
  input  logic                     clk,
  input  logic                     clear_n,
  input  logic                     sample_en,
  input  logic [WIDTH-1:0]         led,
  input  logic                     err_clr,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     pos_valid,
  output logic [1:0]               dir,
  output logic                     locked,
  output logic [LAP_W-1:0]         lap_cnt,
  output logic                     rev,
  output logic                     err
);

  localparam int PW = $clog2(WIDTH);
  localparam int SW = $clog2(LOCK_STEPS + 1);
  localparam logic [SW-1:0] LOCK_CNT  = SW'(LOCK_STEPS);
  localparam logic [1:0]    DIR_NONE  = 2'b00;
  localparam logic [1:0]    DIR_LEFT  = 2'b01;
  localparam logic [1:0]    DIR_RIGHT = 2'b10;

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED, FAULT} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic              pos_valid_q, pos_valid_d;
  logic [1:0]        dir_q, dir_d;
  logic              locked_q, locked_d;
  logic [LAP_W-1:0]  lap_q, lap_d;
  logic              rev_q, rev_d;
  logic              err_q, err_d;
  logic [SW-1:0]     steps_q, steps_d, steps_nxt;
  logic [1:0]        cand_q, cand_d;

  logic [PW-1:0]     q_pos;
  logic              onehot, zero;
  logic              is_hold, is_jump;
  logic [1:0]        step_dir;
  int                diff;

  // Decode the lit position and classify the move relative to the last valid position.
  always_comb begin
    q_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (led[i]) q_pos = PW'(i);
    end
    onehot = ($countones(led) == 1);
    zero   = (led == '0);
    diff   = int'(q_pos) - int'(pos_q);
    if (diff == 1 || diff == -(WIDTH - 1))      step_dir = DIR_LEFT;
    else if (diff == -1 || diff == WIDTH - 1)   step_dir = DIR_RIGHT;
    else                                        step_dir = DIR_NONE;
    is_hold = (diff == 0);
    is_jump = !is_hold && (step_dir == DIR_NONE);
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    pos_valid_d = pos_valid_q;
    dir_d       = dir_q;
    locked_d    = locked_q;
    lap_d       = lap_q;
    steps_d     = steps_q;
    cand_d      = cand_q;
    rev_d       = 1'b0;
    steps_nxt   = steps_q;

    unique case (state_q)
      IDLE: if (sample_en) begin
        if (onehot) begin
          state_d     = TRACK;
          pos_d       = q_pos;
          pos_valid_d = 1'b1;
          steps_d     = '0;
          cand_d      = DIR_NONE;
        end else if (!zero) begin
          state_d = FAULT;
        end
      end

      TRACK: if (sample_en) begin
        if (!onehot || is_jump) begin
          state_d = FAULT;
        end else if (!is_hold) begin
          pos_d     = q_pos;
          steps_nxt = (steps_q == '0 || step_dir == cand_q) ? steps_q + SW'(1) : SW'(1);
          steps_d   = steps_nxt;
          cand_d    = step_dir;
          if (steps_nxt >= LOCK_CNT) begin
            state_d  = LOCKED;
            dir_d    = step_dir;
            locked_d = 1'b1;
          end
        end
      end

      LOCKED: if (sample_en) begin
        if (!onehot || is_jump) begin
          state_d = FAULT;
        end else if (!is_hold) begin
          pos_d = q_pos;
          if (step_dir == dir_q) begin
            // A step in the locked direction that lands on the wrap end closes a lap.
            if ((step_dir == DIR_LEFT  && q_pos == '0) ||
                (step_dir == DIR_RIGHT && q_pos == PW'(WIDTH - 1)))
              lap_d = lap_q + LAP_W'(1);
          end else begin
            state_d  = TRACK;
            steps_d  = SW'(1);
            cand_d   = step_dir;
            dir_d    = DIR_NONE;
            locked_d = 1'b0;
            rev_d    = 1'b1;
          end
        end
      end

      FAULT: if (err_clr) begin
        state_d     = IDLE;
        pos_valid_d = 1'b0;
        dir_d       = DIR_NONE;
        locked_d    = 1'b0;
        steps_d     = '0;
        cand_d      = DIR_NONE;
      end

      default: state_d = IDLE;
    endcase

    err_d = (state_d == FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      dir_q       <= DIR_NONE;
      locked_q    <= 1'b0;
      lap_q       <= '0;
      rev_q       <= 1'b0;
      err_q       <= 1'b0;
      steps_q     <= '0;
      cand_q      <= DIR_NONE;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      dir_q       <= dir_d;
      locked_q    <= locked_d;
      lap_q       <= lap_d;
      rev_q       <= rev_d;
      err_q       <= err_d;
      steps_q     <= steps_d;
      cand_q      <= cand_d;
    end
  end

  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign dir       = dir_q;
  assign locked    = locked_q;
  assign lap_cnt   = lap_q;
  assign rev       = rev_q;
  assign err       = err_q;

endmodule

// File: tb/tb_led_chase_monitor.sv
// Directed self-checking bench for led_chase_monitor (WIDTH=8, LAP_W=8, LOCK_STEPS=2).
module tb_led_chase_monitor;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       sample_en;
  logic [7:0] led;
  logic       err_clr;
  logic [2:0] pos;
  logic       pos_valid;
  logic [1:0] dir;
  logic       locked;
  logic [7:0] lap_cnt;
  logic       rev;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  led_chase_monitor #(.WIDTH(8), .LAP_W(8), .LOCK_STEPS(2)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .sample_en (sample_en),
    .led       (led),
    .err_clr   (err_clr),
    .pos       (pos),
    .pos_valid (pos_valid),
    .dir       (dir),
    .locked    (locked),
    .lap_cnt   (lap_cnt),
    .rev       (rev),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string t, input int e_pos, input int e_pv, input int e_dir,
                            input int e_lock, input int e_lap, input int e_rev, input int e_err);
    check({t, ".pos"},       32'(pos),       32'(e_pos));
    check({t, ".pos_valid"}, 32'(pos_valid), 32'(e_pv));
    check({t, ".dir"},       32'(dir),       32'(e_dir));
    check({t, ".locked"},    32'(locked),    32'(e_lock));
    check({t, ".lap_cnt"},   32'(lap_cnt),   32'(e_lap));
    check({t, ".rev"},       32'(rev),       32'(e_rev));
    check({t, ".err"},       32'(err),       32'(e_err));
  endtask

  // Present one LED value for a single clock, then leave outputs settled 1 time unit after the edge.
  task automatic step(input logic [7:0] v, input logic clr = 1'b0);
    led       = v;
    sample_en = 1'b1;
    err_clr   = clr;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_n   = 1'b0;
    sample_en = 1'b0;
    led       = '0;
    err_clr   = 1'b0;
    #12;
    expect_all("reset", 0, 0, 0, 0, 0, 0, 0);
    clear_n = 1'b1;
    idle_cycle();

    // Lock left after two steps
    step(8'h01); expect_all("t1_01", 0, 1, 0, 0, 0, 0, 0);
    step(8'h02); expect_all("t1_02", 1, 1, 0, 0, 0, 0, 0);
    step(8'h04); expect_all("t1_04", 2, 1, 1, 1, 0, 0, 0);

    // Lap on MSB->LSB wrap while locked left
    step(8'h08); step(8'h10); step(8'h20); step(8'h40);
    step(8'h80); expect_all("t2_80", 7, 1, 1, 1, 0, 0, 0);
    step(8'h01); expect_all("t2_01", 0, 1, 1, 1, 1, 0, 0);
    step(8'h01); expect_all("t2_hold", 0, 1, 1, 1, 1, 0, 0);

    // Reversal out of LOCKED, then relock right
    step(8'h02); step(8'h04); step(8'h08);
    step(8'h04); expect_all("t4_rev", 2, 1, 0, 0, 1, 1, 0);
    idle_cycle(); check("t4_rev_pulse", 32'(rev), 0);
    step(8'h02); expect_all("t4_relock", 1, 1, 2, 1, 1, 0, 0);

    // Right wrap lap, then a jump into FAULT
    step(8'h01);
    step(8'h80); expect_all("t5_wrap", 7, 1, 2, 1, 2, 0, 0);
    step(8'h40); step(8'h20); step(8'h10);
    step(8'h08); expect_all("t5_08", 3, 1, 2, 1, 2, 0, 0);
    step(8'h20);
    check("t5_jump.err", 32'(err), 1);
    check("t5_jump.pos", 32'(pos), 3);
    check("t5_jump.lap", 32'(lap_cnt), 2);
    step(8'h04);
    check("t5_ignored.err", 32'(err), 1);
    check("t5_ignored.pos", 32'(pos), 3);
    step(8'h04, 1'b1);
    check("t5_clr.err",       32'(err),       0);
    check("t5_clr.pos_valid", 32'(pos_valid), 0);
    check("t5_clr.dir",       32'(dir),       0);
    check("t5_clr.locked",    32'(locked),    0);
    check("t5_clr.lap",       32'(lap_cnt),   2);
    step(8'h81);
    check("t5_multi.err",       32'(err),       1);
    check("t5_multi.pos_valid", 32'(pos_valid), 0);
    check("t5_multi.lap",       32'(lap_cnt),   2);

    // Fresh reset, rotate right for a full lap
    #2 clear_n = 1'b0;
    #2 expect_all("t3_reset", 0, 0, 0, 0, 0, 0, 0);
    clear_n = 1'b1;
    idle_cycle();
    step(8'h80); step(8'h40);
    check("t3_40.locked", 32'(locked), 0);
    step(8'h20); expect_all("t3_20", 5, 1, 2, 1, 0, 0, 0);
    step(8'h10); step(8'h08); step(8'h04); step(8'h02);
    step(8'h01); expect_all("t3_01", 0, 1, 2, 1, 0, 0, 0);
    step(8'h80); expect_all("t3_80", 7, 1, 2, 1, 1, 0, 0);

    // Asynchronous reset between clock edges while LOCKED
    #3 clear_n = 1'b0;
    #1 expect_all("t6_async", 0, 0, 0, 0, 0, 0, 0);
    #2 clear_n = 1'b1;
    idle_cycle();
    step(8'h10);
    check("t6_10.pos",       32'(pos),       4);
    check("t6_10.pos_valid", 32'(pos_valid), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
